led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
- Multi-channel LED pattern generator; parametrised successor to the single-counter blinker.
- NUM_CH independent outputs, each runtime-configurable as OFF, ON, BLINK (programmable half-period) or PWM (programmable duty).
- A shared prescaler generates the time base.
- Config is written through a valid/ready port driven by a bench or a future register block.

Parameters:
NUM_CH, 4, number of LED channels (>=1)
DIV, 1000, prescaler divide ratio in clk cycles per tick (>=1)
PERIOD_W, 16, width of blink half-period field
PWM_W, 8, PWM counter/duty width; PWM frame = 2^PWM_W ticks
CH_W, $clog2(NUM_CH) (min 1), channel index width (localparam)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cfg_valid  input  1  config request
cfg_ready  output  1  block can accept config
cfg_ch  input  CH_W  target channel
cfg_mode  input  2  0=OFF 1=ON 2=BLINK 3=PWM
cfg_period  input  PERIOD_W  BLINK half-period in ticks
cfg_duty  input  PWM_W  PWM on-count per frame
cfg_err  output  1  one-cycle pulse: accepted write had cfg_ch >= NUM_CH
tick  output  1  one-cycle prescaler pulse (debug/chaining)
led  output  NUM_CH  LED outputs, registered

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: led=0, tick=0, cfg_ready=0, cfg_err=0.
  - State: prescaler=0; all channels mode=OFF, period=0, duty=0, counters=0.
- Outputs update only on clk rising edges after rst deasserts.
- Reset asserted mid-operation clears everything immediately. No pending config survives.
- cfg_ready:
  - Registered. Rises on the first clk edge after reset release.
  - Drops for exactly one cycle after each accepted write, then returns to 1.
  - Back-to-back writes are therefore accepted at most every 2 cycles.
- Accept: accepted on edge N when cfg_valid=1 and cfg_ready=1. cfg_* fields are sampled only at accept; they are ignored otherwise.
- Valid write (cfg_ch < NUM_CH), applied at edge N, so new led is visible after edge N:
  - mode, period and duty registers are loaded.
  - blink_cnt=0, pwm_cnt=0.
  - led[ch] initial value: OFF->0, ON->1, BLINK->1, PWM->(duty!=0).
- Invalid write (cfg_ch >= NUM_CH): no channel changes; cfg_err=1 for the cycle after edge N. cfg_ready still drops for one cycle.
- Prescaler:
  - Free-running count 0..DIV-1.
  - tick=1 for the cycle following the edge where count wraps DIV-1 -> 0.
  - DIV=1: tick held high continuously.
  - Never disturbed by config writes.
- Per channel, on each cycle with tick=1:
  - OFF / ON: led held at 0 / 1; counters idle.
  - BLINK:
    - Effective half-period P = max(period, 1).
    - blink_cnt increments; when it reaches P-1 it wraps to 0 and led toggles.
    - Result: square wave of period 2P ticks, high first.
  - PWM:
    - pwm_cnt increments mod 2^PWM_W; led <= (pwm_cnt_next < duty).
    - duty=0 is constantly off; duty=2^PWM_W-1 is on for all but one tick per frame.
- Simultaneous tick and write to the same channel: the write wins for that channel. Other channels process the tick normally.
- Counter widths: blink_cnt is PERIOD_W bits, pwm_cnt is PWM_W bits; both wrap silently.

Test Plan:
- Reset: NUM_CH=4, DIV=2, PWM_W=4. Hold rst=0 for 3 clks, then release.
  -> led=0000, cfg_ready=0 during reset; cfg_ready=1 one edge after release; tick toggles every clk.
- ON/OFF and handshake: write ch2 ON, then ch2 OFF with cfg_valid held high.
  -> led[2]=1 after the first accept; cfg_ready low for exactly 1 cycle; second accept 2 cycles later; led[2]=0.
- BLINK: ch0 BLINK, period=3, DIV=2.
  -> led[0] high 6 clks, low 6 clks, repeating (period 12 clks).
  -> period=0 on ch1 gives a toggle every tick.
- PWM: ch1 PWM, duty=4, PWM_W=4, DIV=1.
  -> led[1] high 4 clks, low 12 clks per 16-clk frame.
  -> duty=0 gives constant 0; duty=15 gives a 1-clk low per frame.
- Invalid channel: NUM_CH=3, write cfg_ch=3.
  -> cfg_err pulses 1 cycle; all led unchanged; cfg_ready drops 1 cycle.
- Collision and async reset:
  - Write ch0 on the same edge as a tick while ch3 is blinking -> ch0 takes its new-mode initial value; ch3 advances normally.
  - Assert rst=0 mid-blink between clk edges -> led=0000 immediately, without waiting for clk.

Source files
------------

// File: rtl/led_pattern_gen_if.sv
// Configuration port of the LED pattern generator.
//
// Handshake: a write transfers on a rising clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ch/cfg_mode/cfg_period/cfg_duty only have to be
// stable on that edge; they are ignored at all other times. cfg_ready drops
// for one cycle after every transfer, so a held cfg_valid gets at most one
// transfer every two cycles. cfg_err is a one-cycle pulse, one cycle after a
// transfer that named a channel that does not exist.
interface led_pattern_gen_if #(
  parameter int CH_W     = 2,
  parameter int PERIOD_W = 16,
  parameter int PWM_W    = 8
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PERIOD_W-1:0] cfg_period;
  logic [PWM_W-1:0]    cfg_duty;
  logic                cfg_err;

  // Requester side (bench or register block).
  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
    input  cfg_ready, cfg_err
  );

  // Pattern generator side.
  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator.
// A shared prescaler produces a one-cycle tick every DIV clocks. Each channel
// is independently OFF, ON, BLINK (square wave, 2*max(period,1) ticks, high
// first) or PWM (frame of 2^PWM_W ticks, high while the frame count < duty).
// A config write reloads one channel and restarts its counters; a write that
// lands on a tick edge takes precedence over that tick for its channel.
module led_pattern_gen #(
  parameter int NUM_CH   = 4,
  parameter int DIV      = 1000,
  parameter int PERIOD_W = 16,
  parameter int PWM_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_gen_if.slave  cfg,
  output logic              tick,
  output logic [NUM_CH-1:0] led
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  // Channel count widened by one bit so it is representable next to cfg_ch.
  localparam logic [CH_W:0] NUM_CH_X = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  // Prescaler and handshake state
  logic [PRE_W-1:0]    r_pre_cnt;
  logic                r_tick;
  logic                r_ready;
  logic                r_err;

  // Per-channel state
  mode_e               r_mode      [NUM_CH];
  logic [PERIOD_W-1:0] r_period    [NUM_CH];
  logic [PERIOD_W-1:0] r_blink_cnt [NUM_CH];
  logic [PWM_W-1:0]    r_duty      [NUM_CH];
  logic [PWM_W-1:0]    r_pwm_cnt   [NUM_CH];
  logic [NUM_CH-1:0]   r_led;

  logic                w_accept;
  logic                w_ch_bad;
  logic [NUM_CH-1:0]   w_sel;
  logic [PERIOD_W-1:0] w_blink_last [NUM_CH];
  logic [PWM_W-1:0]    w_pwm_next   [NUM_CH];

  // Transfer decode, per-channel write select and next-count helpers.
  // A half-period of 0 behaves as 1, so its last count is 0 as well.
  always_comb begin
    w_accept = cfg.cfg_valid & r_ready;
    w_ch_bad = ({1'b0, cfg.cfg_ch} >= NUM_CH_X);
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel[i]        = w_accept && (cfg.cfg_ch == CH_W'(i));
      w_blink_last[i] = (r_period[i] == '0) ? '0 : (r_period[i] - 1'b1);
      w_pwm_next[i]   = r_pwm_cnt[i] + 1'b1;
    end
  end

  // Free-running prescaler; tick is high the cycle after the count wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick    <= (r_pre_cnt == PRE_LAST);
      r_pre_cnt <= (r_pre_cnt == PRE_LAST) ? '0 : (r_pre_cnt + 1'b1);
    end
  end

  // Ready rests high and blinks low for one cycle after each transfer;
  // err flags a transfer to a non-existent channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= ~w_accept;
      r_err   <= w_accept & w_ch_bad;
    end
  end

  // Channel engines: a write reloads the channel, otherwise a tick advances it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_mode[i]      <= MODE_OFF;
        r_period[i]    <= '0;
        r_blink_cnt[i] <= '0;
        r_duty[i]      <= '0;
        r_pwm_cnt[i]   <= '0;
      end
      r_led <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_sel[i]) begin
          r_mode[i]      <= mode_e'(cfg.cfg_mode);
          r_period[i]    <= cfg.cfg_period;
          r_duty[i]      <= cfg.cfg_duty;
          r_blink_cnt[i] <= '0;
          r_pwm_cnt[i]   <= '0;
          case (mode_e'(cfg.cfg_mode))
            MODE_OFF:   r_led[i] <= 1'b0;
            MODE_ON:    r_led[i] <= 1'b1;
            MODE_BLINK: r_led[i] <= 1'b1;
            default:    r_led[i] <= (cfg.cfg_duty != '0);
          endcase
        end else if (r_tick) begin
          case (r_mode[i])
            MODE_OFF: r_led[i] <= 1'b0;
            MODE_ON:  r_led[i] <= 1'b1;
            MODE_BLINK: begin
              if (r_blink_cnt[i] == w_blink_last[i]) begin
                r_blink_cnt[i] <= '0;
                r_led[i]       <= ~r_led[i];
              end else begin
                r_blink_cnt[i] <= r_blink_cnt[i] + 1'b1;
              end
            end
            default: begin
              r_pwm_cnt[i] <= w_pwm_next[i];
              r_led[i]     <= (w_pwm_next[i] < r_duty[i]);
            end
          endcase
        end
      end
    end
  end

  assign tick          = r_tick;
  assign led           = r_led;
  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_err   = r_err;

endmodule
